// File: rtl/tensor_streamer.sv
// Snapshots a 3x8x8 signed tensor on start and streams it out one element per
// accepted valid/ready beat, row fastest, then column, then channel.
module tensor_streamer #(
    parameter int WIDTH = 17
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic signed [2:0][7:0][7:0][WIDTH-1:0]    tensor_in,
    input  logic                                      out_ready,
    output logic                                      out_valid,
    output logic signed [WIDTH-1:0]                   out_data,
    output logic [1:0]                                cha_addr,
    output logic [2:0]                                col_addr,
    output logic [2:0]                                row_addr,
    output logic                                      out_last,
    output logic                                      busy,
    output logic                                      done
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                      state_reg;
    logic                        valid_reg;
    logic                        last_reg;
    logic                        busy_reg;
    logic                        done_reg;
    logic signed [WIDTH-1:0]     data_reg;
    logic [1:0]                  cha_reg;
    logic [2:0]                  col_reg;
    logic [2:0]                  row_reg;

    logic [7:0][7:0][WIDTH-1:0]  snapshot_reg [0:2];

    logic                        capture;
    logic [1:0]                  cha_next;
    logic [2:0]                  col_next;
    logic [2:0]                  row_next;
    logic                        last_next;

    assign capture = (state_reg == IDLE) && start;

    // One capture register bank per channel; only written on an accepted start.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_snap
            always_ff @(posedge clk) begin
                if (rst) begin
                    snapshot_reg[gi] <= '0;
                end else if (capture) begin
                    snapshot_reg[gi] <= tensor_in[gi];
                end
            end
        end
    endgenerate

    // Address of the element following the one currently presented.
    always_comb begin
        row_next = row_reg + 3'd1;
        col_next = col_reg;
        cha_next = cha_reg;
        if (row_reg == 3'd7) begin
            col_next = col_reg + 3'd1;
            if (col_reg == 3'd7) begin
                cha_next = cha_reg + 2'd1;
            end
        end
        last_next = (cha_next == 2'd2) && (col_next == 3'd7) && (row_next == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            data_reg  <= '0;
            cha_reg   <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Snapshot is not loaded yet, so the first element comes straight from the input.
                        state_reg <= STREAM;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        last_reg  <= 1'b0;
                        data_reg  <= tensor_in[0][0][0];
                        cha_reg   <= 2'd0;
                        col_reg   <= 3'd0;
                        row_reg   <= 3'd0;
                    end
                end
                STREAM: begin
                    if (valid_reg && out_ready) begin
                        if (last_reg) begin
                            state_reg <= IDLE;
                            valid_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                            last_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            cha_reg  <= cha_next;
                            col_reg  <= col_next;
                            row_reg  <= row_next;
                            data_reg <= snapshot_reg[cha_next][col_next][row_next];
                            last_reg <= last_next;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign cha_addr  = cha_reg;
    assign col_addr  = col_reg;
    assign row_addr  = row_reg;
    assign out_last  = last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_tensor_streamer.sv
// Scoreboard bench for tensor_streamer: expected beats are queued at start and
// popped on every valid/ready transfer.
module tb_tensor_streamer;

    localparam int WIDTH = 17;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       cha;
        logic [2:0]       col;
        logic [2:0]       row;
        logic             last;
    } beat_t;

    logic                                    clk;
    logic                                    rst;
    logic                                    start;
    logic signed [2:0][7:0][7:0][WIDTH-1:0]  tensor_in;
    logic                                    out_ready;
    logic                                    out_valid;
    logic signed [WIDTH-1:0]                 out_data;
    logic [1:0]                              cha_addr;
    logic [2:0]                              col_addr;
    logic [2:0]                              row_addr;
    logic                                    out_last;
    logic                                    busy;
    logic                                    done;

    int    total;
    int    bad;
    beat_t exp_q[$];
    beat_t e;
    beat_t got;
    beat_t held;
    int    beats;
    int    cyc;
    int    dones;
    logic  hold_pending;

    tensor_streamer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tensor_in (tensor_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cha_addr  (cha_addr),
        .col_addr  (col_addr),
        .row_addr  (row_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got = '{data: out_data, cha: cha_addr, col: col_addr, row: row_addr, last: out_last};

    task automatic fill_index(input int offset);
        for (int c = 0; c < 3; c++)
            for (int co = 0; co < 8; co++)
                for (int r = 0; r < 8; r++)
                    tensor_in[c][co][r] = WIDTH'(c * 64 + co * 8 + r + offset);
    endtask

    task automatic fill_const(input logic [WIDTH-1:0] v);
        for (int c = 0; c < 3; c++)
            for (int co = 0; co < 8; co++)
                for (int r = 0; r < 8; r++)
                    tensor_in[c][co][r] = v;
    endtask

    task automatic push_expected();
        beat_t b;
        for (int c = 0; c < 3; c++)
            for (int co = 0; co < 8; co++)
                for (int r = 0; r < 8; r++) begin
                    b.data = tensor_in[c][co][r];
                    b.cha  = 2'(c);
                    b.col  = 3'(co);
                    b.row  = 3'(r);
                    b.last = (c == 2) && (co == 7) && (r == 7);
                    exp_q.push_back(b);
                end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        push_expected();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        fill_index(5);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({out_valid, out_last, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got v/l/b/d=%b want 0000", {out_valid, out_last, busy, done});
        end
        total++;
        if ({out_data, cha_addr, col_addr, row_addr} !== '0) begin
            bad++;
            $display("FAIL reset_data: got data=%h addr=%0d,%0d,%0d want 0", out_data, cha_addr, col_addr, row_addr);
        end
        $display("test_reset: checked idle outputs");
    endtask

    task automatic test_stream();
        fill_index(0);
        out_ready = 1'b1;
        pulse_start();
        beats = 0; cyc = 0;
        while (beats < 192 && cyc < 1000) begin
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL stream_gap: beat %0d got valid=%b busy=%b want 1 1", beats, out_valid, busy);
            end
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL stream_beat %0d: got %h want %h", beats, got, e);
                end
                beats++;
            end
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (beats != 192 || cyc != 192) begin
            bad++;
            $display("FAIL stream_count: got beats=%0d cycles=%0d want 192 192", beats, cyc);
        end
        total++;
        if ({done, out_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL stream_done: got done/valid/busy=%b want 100", {done, out_valid, busy});
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL stream_done_width: got done=%b want 0", done);
        end
        $display("test_stream: %0d beats in %0d cycles", beats, cyc);
    endtask

    task automatic test_backpressure();
        fill_index(300);
        out_ready = 1'b0;
        pulse_start();
        beats = 0; cyc = 0; hold_pending = 1'b0;
        while (beats < 192 && cyc < 1000) begin
            if (hold_pending) begin
                total++;
                if (out_valid !== 1'b1 || got !== held) begin
                    bad++;
                    $display("FAIL hold_stable: got valid=%b %h want 1 %h", out_valid, got, held);
                end
            end
            out_ready = (cyc % 2 == 0);
            hold_pending = out_valid && !out_ready;
            held = got;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL bp_beat %0d: got %h want %h", beats, got, e);
                end
                beats++;
            end
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (beats != 192 || exp_q.size() != 0 || done !== 1'b1) begin
            bad++;
            $display("FAIL bp_count: got beats=%0d left=%0d done=%b want 192 0 1", beats, exp_q.size(), done);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        $display("test_backpressure: %0d beats in %0d cycles", beats, cyc);
    endtask

    task automatic test_snapshot();
        fill_const({WIDTH{1'b1}});
        out_ready = 1'b1;
        pulse_start();
        beats = 0; cyc = 0;
        while (beats < 192 && cyc < 1000) begin
            if (beats == 20) fill_const('0);
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total++;
                if (got !== e || out_data !== -17'sd1) begin
                    bad++;
                    $display("FAIL snap_beat %0d: got %h want %h", beats, got, e);
                end
                beats++;
            end
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (beats != 192 || done !== 1'b1) begin
            bad++;
            $display("FAIL snap_count: got beats=%0d done=%b want 192 1", beats, done);
        end
        @(posedge clk); #1;
        $display("test_snapshot: %0d beats of -1", beats);
    endtask

    task automatic test_start_ignored();
        fill_index(2000);
        out_ready = 1'b1;
        pulse_start();
        fill_index(9000);
        beats = 0; cyc = 0; dones = 0;
        while (beats < 192 && cyc < 1000) begin
            start = (beats == 5) || (beats == 191);
            if (done) dones++;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL ign_beat %0d: got %h want %h", beats, got, e);
                end
                beats++;
            end
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL ign_restart: cycle %0d got valid=%b busy=%b want 0 0", i, out_valid, busy);
            end
            @(posedge clk); #1;
        end
        total++;
        if (dones != 1 || beats != 192) begin
            bad++;
            $display("FAIL ign_done_count: got dones=%0d beats=%0d want 1 192", dones, beats);
        end
        $display("test_start_ignored: dones=%0d", dones);
    endtask

    task automatic test_abort();
        fill_index(4000);
        out_ready = 1'b1;
        pulse_start();
        beats = 0; cyc = 0;
        while (beats < 100 && cyc < 1000) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL abort_beat %0d: got %h want %h", beats, got, e);
                end
                beats++;
            end
            @(posedge clk); #1; cyc++;
        end
        total++;
        if ({cha_addr, col_addr, row_addr} !== {2'd1, 3'd4, 3'd4} || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL abort_point: got %0d,%0d,%0d valid=%b want 1,4,4 1", cha_addr, col_addr, row_addr, out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        total++;
        if ({out_valid, busy, done, out_last} !== 4'b0000 || {out_data, cha_addr, col_addr, row_addr} !== '0) begin
            bad++;
            $display("FAIL abort_state: got v/b/d/l=%b data=%h want 0000 0", {out_valid, busy, done, out_last}, out_data);
        end
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_done: got done=%b valid=%b want 0 0", done, out_valid);
            end
        end
        fill_index(77);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            total++;
            if (out_valid !== 1'b1 || got !== e) begin
                bad++;
                $display("FAIL abort_restart %0d: got valid=%b %h want 1 %h", i, out_valid, got, e);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        $display("test_abort: aborted at beat %0d and restarted", beats);
    endtask

    task automatic test_stall_first();
        fill_index(512);
        out_ready = 1'b0;
        pulse_start();
        e = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || got !== e) begin
                bad++;
                $display("FAIL stall_first %0d: got valid=%b busy=%b %h want 1 1 %h", i, out_valid, busy, got, e);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        beats = 0; cyc = 0;
        while (beats < 192 && cyc < 1000) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL stall_beat %0d: got %h want %h", beats, got, e);
                end
                beats++;
            end
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (beats != 192 || done !== 1'b1) begin
            bad++;
            $display("FAIL stall_count: got beats=%0d done=%b want 192 1", beats, done);
        end
        $display("test_stall_first: held 10 cycles then %0d beats", beats);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        tensor_in = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_snapshot();
        test_start_ignored();
        test_abort();
        test_stall_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
